// File: rtl/bp_pkg.sv
// Shared types, constants and counter helpers for the fetch-side branch predictor.
package bp_pkg;

  localparam int BP_ENTRIES = 32;
  localparam int BP_ADDR_W  = 10;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_ADDR_W - BP_IDX_W;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

  // 2-bit direction counter: MSB set means predict taken
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_ADDR_W-1:0] target;
    logic [1:0]           ctr;
  } bp_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    case (c)
      CTR_SNT: return CTR_WNT;
      CTR_WNT: return CTR_WT;
      default: return CTR_ST;
    endcase
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    case (c)
      CTR_ST:  return CTR_WT;
      CTR_WT:  return CTR_WNT;
      default: return CTR_SNT;
    endcase
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Lookup, prediction and training signals between fetch/execute and the predictor.
interface branch_target_predictor_if #(parameter int ADDR_W = 10);

  logic [ADDR_W-1:0] lookup_pc;
  logic              lookup_stall;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_en;
  logic [ADDR_W-1:0] upd_pc;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_taken;
  logic              ready;

  modport master (
    output lookup_pc, lookup_stall, upd_en, upd_pc, upd_target, upd_taken,
    input  pred_hit, pred_taken, pred_target, ready
  );

  modport slave (
    input  lookup_pc, lookup_stall, upd_en, upd_pc, upd_target, upd_taken,
    output pred_hit, pred_taken, pred_target, ready
  );

endinterface

// File: rtl/bp_sat_counter.sv
// Next value of a 2-bit saturating direction counter given the resolved outcome.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);

  assign ctr_nxt = taken ? sat_inc(ctr) : sat_dec(ctr);

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Table is cleared one entry per cycle after reset; lookups are registered so
// the prediction lines up with the synchronous program ROM output.
//
// state   | meaning
// BP_INIT | walking init_idx through the table clearing valid/ctr; outputs held 0
// BP_RUN  | table live: lookups registered, execute-stage updates written
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int ADDR_W  = BP_ADDR_W,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_target_predictor_if.slave bus
);

  localparam int TAG_W = ADDR_W - IDX_W;

  bp_state_t         state_q;
  logic [IDX_W-1:0]  init_idx_q;
  bp_entry_t         table_q [ENTRIES];

  logic              hit_q;
  logic              taken_q;
  logic [ADDR_W-1:0] target_q;
  logic              ready_q;

  logic [IDX_W-1:0]  u_idx;
  logic [TAG_W-1:0]  u_tag;
  bp_entry_t         u_ent;
  logic              u_hit;
  logic [1:0]        ctr_nxt;
  bp_entry_t         new_ent;
  logic              wr_en;

  logic [IDX_W-1:0]  l_idx;
  logic [TAG_W-1:0]  l_tag;
  bp_entry_t         l_ent;
  logic              l_hit;

  assign u_idx = bus.upd_pc[IDX_W-1:0];
  assign u_tag = bus.upd_pc[ADDR_W-1:IDX_W];
  assign u_ent = table_q[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

  assign l_idx = bus.lookup_pc[IDX_W-1:0];
  assign l_tag = bus.lookup_pc[ADDR_W-1:IDX_W];

  bp_sat_counter u_sat (
    .ctr     (u_ent.ctr),
    .taken   (bus.upd_taken),
    .ctr_nxt (ctr_nxt)
  );

  // Training: train the hit entry, allocate on a taken miss, ignore a not-taken miss
  always_comb begin
    new_ent = u_ent;
    wr_en   = 1'b0;
    if (state_q == BP_RUN && bus.upd_en) begin
      if (u_hit) begin
        new_ent.ctr = ctr_nxt;
        if (bus.upd_taken) new_ent.target = bus.upd_target;
        wr_en = 1'b1;
      end else if (bus.upd_taken) begin
        new_ent.valid  = 1'b1;
        new_ent.tag    = u_tag;
        new_ent.target = bus.upd_target;
        new_ent.ctr    = CTR_WT;
        wr_en          = 1'b1;
      end
    end
  end

  // Lookup with write-first bypass so a same-index update is visible immediately
  always_comb begin
    l_ent = (wr_en && (u_idx == l_idx)) ? new_ent : table_q[l_idx];
    l_hit = l_ent.valid && (l_ent.tag == l_tag);
  end

  // Sequencer, table write port and registered prediction outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BP_INIT;
      init_idx_q <= '0;
      hit_q      <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        BP_INIT: begin
          table_q[init_idx_q].valid <= 1'b0;
          table_q[init_idx_q].ctr   <= CTR_SNT;
          init_idx_q <= init_idx_q + 1'b1;
          hit_q      <= 1'b0;
          taken_q    <= 1'b0;
          target_q   <= '0;
          if (init_idx_q == IDX_W'(ENTRIES - 1)) begin
            state_q <= BP_RUN;
            ready_q <= 1'b1;
          end
        end
        BP_RUN: begin
          if (wr_en) table_q[u_idx] <= new_ent;
          if (!bus.lookup_stall) begin
            hit_q    <= l_hit;
            taken_q  <= l_hit && (l_ent.ctr >= CTR_WT);
            target_q <= l_hit ? l_ent.target : '0;
          end
        end
        default: state_q <= BP_INIT;
      endcase
    end
  end

  assign bus.pred_hit    = hit_q;
  assign bus.pred_taken  = taken_q;
  assign bus.pred_target = target_q;
  assign bus.ready       = ready_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: directed vectors with fixed expectations plus random
// traffic compared against an entry-level behavioural model.
module tb_branch_target_predictor;

  localparam int N  = 32;
  localparam int AW = 10;

  logic clk;
  logic rst;

  branch_target_predictor_if #(.ADDR_W(AW)) bus ();

  branch_target_predictor #(.ENTRIES(N), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  int m_valid [N];
  int m_tag   [N];
  int m_tgt   [N];
  int m_ctr   [N];
  int m_init;
  bit m_ready, m_hit, m_taken;
  int m_target;

  typedef struct {
    logic          upd_en;
    logic [AW-1:0] upd_pc;
    logic [AW-1:0] upd_tgt;
    logic          upd_taken;
    logic [AW-1:0] lk_pc;
    logic          e_hit;
    logic          e_taken;
    logic [AW-1:0] e_tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ue, input logic [AW-1:0] upc, input logic [AW-1:0] utg,
                              input logic ut, input logic [AW-1:0] lpc, input logic eh,
                              input logic et, input logic [AW-1:0] etg);
    vec_t v;
    v.upd_en = ue; v.upd_pc = upc; v.upd_tgt = utg; v.upd_taken = ut;
    v.lk_pc = lpc; v.e_hit = eh; v.e_taken = et; v.e_tgt = etg;
    return v;
  endfunction

  function automatic logic [12:0] dut_pack();
    return {bus.ready, bus.pred_hit, bus.pred_taken, bus.pred_target};
  endfunction

  function automatic logic [12:0] model_pack();
    return {m_ready, m_hit, m_taken, 10'(m_target)};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ready/hit/taken/target=%b/%b/%b/%h expected %b/%b/%b/%h",
               name, act[12], act[11], act[10], act[9:0], exp[12], exp[11], exp[10], exp[9:0]);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    int idx, tag;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
      end
      m_init = 0; m_ready = 0; m_hit = 0; m_taken = 0; m_target = 0;
    end else if (m_init < N) begin
      m_init++;
      m_ready = (m_init == N);
      m_hit = 0; m_taken = 0; m_target = 0;
    end else begin
      if (bus.upd_en) begin
        idx = int'(bus.upd_pc) % N;
        tag = int'(bus.upd_pc) / N;
        if (m_valid[idx] != 0 && m_tag[idx] == tag) begin
          if (bus.upd_taken) begin
            m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
            m_tgt[idx] = int'(bus.upd_target);
          end else begin
            m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
          end
        end else if (bus.upd_taken) begin
          m_valid[idx] = 1; m_tag[idx] = tag;
          m_tgt[idx] = int'(bus.upd_target); m_ctr[idx] = 2;
        end
      end
      if (!bus.lookup_stall) begin
        idx = int'(bus.lookup_pc) % N;
        tag = int'(bus.lookup_pc) / N;
        m_hit    = (m_valid[idx] != 0 && m_tag[idx] == tag);
        m_taken  = m_hit && (m_ctr[idx] >= 2);
        m_target = m_hit ? m_tgt[idx] : 0;
      end
    end
  endtask

  task automatic tick(input string name);
    model_step();
    @(posedge clk);
    #1;
    check({name, "_model"}, dut_pack(), model_pack());
  endtask

  task automatic drive(input logic ue, input logic [AW-1:0] upc, input logic [AW-1:0] utg,
                       input logic ut, input logic [AW-1:0] lpc, input logic st);
    bus.upd_en = ue; bus.upd_pc = upc; bus.upd_target = utg; bus.upd_taken = ut;
    bus.lookup_pc = lpc; bus.lookup_stall = st;
  endtask

  logic [AW-1:0] pop_pc [5];

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    m_init = 0;

    // index 5: 0x045 tag 2, 0x065 tag 3; index 2: 0x0A2
    vecs.push_back(mk(1, 10'h045, 10'h120, 1, 10'h000, 0, 0, 10'h000)); // allocate, lookup elsewhere
    vecs.push_back(mk(0, 10'h000, 10'h000, 0, 10'h045, 1, 1, 10'h120)); // predict allocated
    vecs.push_back(mk(0, 10'h000, 10'h000, 0, 10'h065, 0, 0, 10'h000)); // same index, other tag
    vecs.push_back(mk(1, 10'h045, 10'h120, 1, 10'h045, 1, 1, 10'h120)); // ctr 3
    vecs.push_back(mk(1, 10'h045, 10'h120, 1, 10'h045, 1, 1, 10'h120)); // stays 3
    vecs.push_back(mk(1, 10'h045, 10'h120, 1, 10'h045, 1, 1, 10'h120)); // stays 3
    vecs.push_back(mk(1, 10'h045, 10'h000, 0, 10'h045, 1, 1, 10'h120)); // 2: still taken
    vecs.push_back(mk(1, 10'h045, 10'h000, 0, 10'h045, 1, 0, 10'h120)); // 1
    vecs.push_back(mk(1, 10'h045, 10'h000, 0, 10'h045, 1, 0, 10'h120)); // 0
    vecs.push_back(mk(1, 10'h045, 10'h000, 0, 10'h045, 1, 0, 10'h120)); // stays 0
    vecs.push_back(mk(1, 10'h045, 10'h120, 1, 10'h045, 1, 0, 10'h120)); // 1: proves no wrap
    vecs.push_back(mk(1, 10'h045, 10'h120, 1, 10'h045, 1, 1, 10'h120)); // 2
    vecs.push_back(mk(1, 10'h0C7, 10'h0AA, 0, 10'h0C7, 0, 0, 10'h000)); // NT miss: no allocate
    vecs.push_back(mk(0, 10'h000, 10'h000, 0, 10'h0C7, 0, 0, 10'h000));
    vecs.push_back(mk(1, 10'h0A2, 10'h010, 1, 10'h0A2, 1, 1, 10'h010)); // write-first bypass
    vecs.push_back(mk(0, 10'h000, 10'h000, 0, 10'h0A2, 1, 1, 10'h010));
    vecs.push_back(mk(1, 10'h0A3, 10'h055, 1, 10'h045, 1, 1, 10'h120)); // other index unaffected
    vecs.push_back(mk(1, 10'h0A2, 10'h3FF, 0, 10'h0A2, 1, 0, 10'h010)); // NT keeps target
    vecs.push_back(mk(1, 10'h045, 10'h200, 1, 10'h045, 1, 1, 10'h200)); // T retargets

    // reset held 3 cycles, lookups/updates to 0x045 throughout INIT
    repeat (3) tick("reset");
    check("reset_state", dut_pack(), 13'h0000);
    rst = 1'b1;
    drive(1'b1, 10'h045, 10'h120, 1'b1, 10'h045, 1'b0);
    for (int k = 1; k <= N; k++) begin
      tick("init");
      check($sformatf("init_ready_c%0d", k), dut_pack(), {(k == N), 12'h000});
    end
    drive(1'b0, '0, '0, 1'b0, 10'h045, 1'b0);
    tick("post_init");
    check("init_upd_ignored", dut_pack(), 13'h1000);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].upd_en, vecs[i].upd_pc, vecs[i].upd_tgt, vecs[i].upd_taken, vecs[i].lk_pc, 1'b0);
      tick("vec");
      check($sformatf("vec%0d", i), dut_pack(), {1'b1, vecs[i].e_hit, vecs[i].e_taken, vecs[i].e_tgt});
    end

    // stall holds outputs even while the looked-up entry is trained down
    drive(1'b1, 10'h045, 10'h120, 1'b1, 10'h045, 1'b0);
    tick("stall_setup");
    check("stall_setup", dut_pack(), {3'b111, 10'h120});
    for (int k = 0; k < 4; k++) begin
      drive((k < 2), 10'h045, 10'h000, 1'b0, 10'h000, 1'b1);
      tick("stall");
      check($sformatf("stall_hold%0d", k), dut_pack(), {3'b111, 10'h120});
    end
    drive(1'b0, '0, '0, 1'b0, 10'h045, 1'b0);
    tick("unstall");
    check("stall_release", dut_pack(), {3'b110, 10'h120});

    // random traffic on a small address set to get plenty of aliasing
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 1) == 1),
            AW'($urandom_range(0, 3) * N + $urandom_range(0, 7)),
            AW'($urandom_range(0, 1023)),
            ($urandom_range(0, 2) != 0),
            AW'($urandom_range(0, 3) * N + $urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0));
      tick("rand");
    end

    // reset in the middle of operation
    pop_pc[0] = 10'h101; pop_pc[1] = 10'h142; pop_pc[2] = 10'h1E3;
    pop_pc[3] = 10'h204; pop_pc[4] = 10'h3C5;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, pop_pc[i], AW'(10'h050 + i), 1'b1, 10'h000, 1'b0);
      tick("populate");
    end
    drive(1'b0, '0, '0, 1'b0, pop_pc[0], 1'b0);
    tick("pre_rst");
    check("pre_rst_hit", dut_pack(), {3'b111, 10'h050});
    rst = 1'b0;
    tick("mid_rst");
    check("mid_rst_outputs", dut_pack(), 13'h0000);
    rst = 1'b1;
    drive(1'b1, pop_pc[1], 10'h077, 1'b1, pop_pc[1], 1'b0);
    for (int k = 1; k <= N; k++) begin
      tick("reinit");
      check($sformatf("reinit_ready_c%0d", k), dut_pack(), {(k == N), 12'h000});
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, 1'b0, pop_pc[i], 1'b0);
      tick("after_rst");
      check($sformatf("after_rst_miss%0d", i), dut_pack(), 13'h1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Fetch-side branch predictor and branch target buffer. It sits directly upstream of the fetch latch.
- It is looked up with the address driven to the program ROM. Its registered prediction emerges on the same cycle as the ROM instruction, where it selects the next PC and the alternate address.
- Execute stage trains it with resolved branch outcomes.
- Direct-mapped table; each entry holds a valid bit, a tag, a target and a 2-bit saturating counter.

Parameters:
- ENTRIES, 32, table depth; power of two, minimum 4.
- ADDR_W, 10, instruction address width.
- IDX_W, $clog2(ENTRIES), index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- lookup_pc  in  ADDR_W  address presented to program ROM this cycle
- lookup_stall  in  1  fetch stalled; hold prediction outputs
- pred_hit  out  1  registered: lookup_pc matched a valid entry
- pred_taken  out  1  registered: hit and counter MSB set
- pred_target  out  ADDR_W  registered: stored target (0 on miss)
- upd_en  in  1  execute holds a conditional branch this cycle
- upd_pc  in  ADDR_W  address of the resolved branch
- upd_target  in  ADDR_W  branch destination
- upd_taken  in  1  resolved outcome
- ready  out  1  table initialised; predictions valid

Behaviour:
- Indexing:
  - index = pc[IDX_W-1:0]
  - tag = pc[ADDR_W-1:IDX_W]
  - hit = valid & tag match
- Reset (rst==0 at a posedge):
  - pred_hit=0, pred_taken=0, pred_target=0, ready=0.
  - State=INIT, init index=0.
  - Asserting reset mid-INIT or mid-RUN restarts INIT from index 0.
- INIT state:
  - Each cycle clears valid and counter of entry init_idx, then increments init_idx.
  - After clearing entry ENTRIES-1, moves to RUN next cycle. ready=1 from that edge, exactly ENTRIES cycles after rst deasserts.
  - During INIT, upd_en is ignored and registered outputs are forced to 0.
- RUN state, lookup:
  - 1-cycle latency: lookup_pc sampled at edge N drives the outputs after edge N, aligned with the synchronous ROM data.
  - lookup_stall=1 holds all three outputs unchanged, including against an update to the same entry.
- RUN state, update (upd_en=1, written at the edge):
  - Hit and taken: counter = min(counter+1, 3); target = upd_target.
  - Hit and not taken: counter = max(counter-1, 0); target unchanged.
  - Miss and taken: allocate, replacing any occupant. Sets valid=1, tag, target=upd_target, counter=2 (weakly taken).
  - Miss and not taken: no change.
- Same-cycle lookup and update to the same index (not stalled): the registered output reflects the post-update entry (write-first bypass). A different index has no interaction.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. pred_taken = hit & counter[1].
- pred_target is 0 whenever pred_hit=0.
- Address arithmetic is not performed here. Fall-through (pc+1) selection stays in the top level.

Decomposition:
- Shared package bp_pkg:
  - typedef enum {BP_INIT, BP_RUN} bp_state_t
  - 2-bit counter constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST
  - Packed struct bp_entry_t {valid, tag, target, ctr}, parameterised by width constants
  - Saturating inc/dec functions
- One natural sub-module: bp_sat_counter, the combinational next-counter given current value and outcome. Reused by any future predictor variant.
- Table storage is an inline register array, not separate RAM, because of the reset clear and the bypass.

Test Plan:
- Init: hold rst=0 for 3 cycles, release.
  - ready=0 for exactly 32 cycles, then 1.
  - Lookup of 0x045 at any point during INIT → pred_hit=0, pred_taken=0.
  - A taken update to 0x045 during INIT → later lookup of 0x045 misses.
- Allocate/predict: upd 0x045 taken target 0x120, then lookup 0x045 → next cycle hit=1, taken=1, target=0x120.
  - Lookup 0x065 (same index, different tag) → hit=0.
- Saturation/hysteresis, after allocate (ctr=2):
  - Three taken updates → ctr=3, stays 3.
  - One not-taken → taken still 1.
  - Second not-taken → taken=0, hit=1.
  - Two more not-taken → ctr stays 0.
  - Miss with not-taken → no allocate.
- Bypass: same cycle, lookup_pc=0x0A2 and first-time taken update 0x0A2→0x010 → following cycle hit=1, taken=1, target=0x010.
- Stall: prediction for 0x045 (taken, 0x120) present; assert lookup_stall 4 cycles while changing lookup_pc to 0x000 and updating 0x045 not-taken twice → outputs stay hit=1/taken=1/0x120; after deassert, lookup 0x045 → taken=0.
- Reset mid-operation: populate 5 entries, assert rst at an arbitrary cycle → outputs 0 next edge, ready=0 for 32 cycles, all previous entries miss afterwards.
